// File: rtl/ascon_p.sv
// Ascon p^12 permutation, one round per clock on a 5-lane registered state.
// A load pulse re-arms the round counter; done marks a completed permutation.
module ascon_p #(
    parameter int BW = 64
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load,
    input  logic [5*BW-1:0] s_in,
    output logic [5*BW-1:0] s_out,
    output logic [3:0]    r,
    output logic          done
);

    localparam logic [3:0] LAST_ROUND = 4'd12;

    logic [5*BW-1:0] state_r;
    logic [3:0]      r_r;
    logic            done_r;
    logic [5*BW-1:0] round_in_s;
    logic [5*BW-1:0] round_out_s;

    function automatic logic [BW-1:0] ror(input logic [BW-1:0] v, input int unsigned n);
        return (v >> n) | (v << (BW - n));
    endfunction

    function automatic logic [5*BW-1:0] round_f(input logic [5*BW-1:0] s, input logic [3:0] idx);
        logic [BW-1:0] x0, x1, x2, x3, x4;
        logic [BW-1:0] t0, t1, t2, t3, t4;
        logic [7:0]    rc;
        x0 = s[5*BW-1:4*BW];
        x1 = s[4*BW-1:3*BW];
        x2 = s[3*BW-1:2*BW];
        x3 = s[2*BW-1:BW];
        x4 = s[BW-1:0];
        rc = {4'hF - idx, idx};
        x2 = x2 ^ {{(BW-8){1'b0}}, rc};
        // Bit-sliced 5-bit S-box (chi-like core with linear pre/post mixing).
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // Round 0 consumes s_in directly; later rounds iterate on the state.
    always_comb begin
        round_in_s = state_r;
        if (r_r == 4'd0) begin
            round_in_s = s_in;
        end else begin
            round_in_s = state_r;
        end
        round_out_s = round_f(round_in_s, r_r);
    end

    // State, round counter and completion flag; load overrides any round in flight.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_r <= '0;
            r_r     <= 4'd0;
            done_r  <= 1'b0;
        end else if (load) begin
            r_r    <= 4'd0;
            done_r <= 1'b0;
        end else if (r_r < LAST_ROUND) begin
            state_r <= round_out_s;
            r_r     <= r_r + 4'd1;
            done_r  <= (r_r == (LAST_ROUND - 4'd1));
        end else begin
            state_r <= state_r;
            r_r     <= r_r;
            done_r  <= done_r;
        end
    end

    assign s_out = state_r;
    assign r     = r_r;
    assign done  = done_r;

endmodule

// File: tb/tb_ascon_p.sv
// Scoreboard bench for ascon_p: stimulus queues expected results, a monitor
// compares s_out each time done rises.
module tb_ascon_p;

    logic         clk;
    logic         rstn;
    logic         load;
    logic [319:0] s_in;
    logic [319:0] s_out;
    logic [3:0]   r;
    logic         done;

    int n_vec = 0;
    int n_err = 0;
    logic [319:0] sb[$];

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam logic [7:0] RCON [12] = '{
        8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

    localparam logic [319:0] KAT_IN  = {64'h00400C0000000100, 256'h0};
    localparam logic [319:0] KAT_OUT = {64'hee9398aadb67f03d, 64'h8bb21831c60f1002,
                                        64'hb48a92db98d5da62, 64'h43189921b8f8e3e8,
                                        64'h348fa5c9d525e140};

    ascon_p #(.BW(64)) dut (
        .clk(clk), .rstn(rstn), .load(load), .s_in(s_in),
        .s_out(s_out), .r(r), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        logic [127:0] d;
        d = {v, v};
        return d[n +: 64];
    endfunction

    // Reference p^12: table-driven S-box applied column by column.
    function automatic logic [319:0] model_p12(input logic [319:0] s);
        logic [63:0] x [5];
        logic [4:0]  col;
        logic [4:0]  o;
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
        for (int rnd = 0; rnd < 12; rnd++) begin
            x[2][7:0] = x[2][7:0] ^ RCON[rnd];
            for (int j = 0; j < 64; j++) begin
                col = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
                o = SBOX[col];
                x[0][j] = o[4]; x[1][j] = o[3]; x[2][j] = o[2];
                x[3][j] = o[1]; x[4][j] = o[0];
            end
            x[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
            x[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
            x[2] = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
            x[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
            x[4] = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic check(input string name, input logic [319:0] got, input logic [319:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic start(input logic [319:0] v, input bit expect_result);
        @(negedge clk);
        s_in = v;
        load = 1'b1;
        if (expect_result) sb.push_back((v == KAT_IN) ? KAT_OUT : model_p12(v));
        @(posedge clk); #1;
        check("load_r", {316'd0, r}, 320'd0);
        check("load_done", {319'd0, done}, 320'd0);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_r(input logic [3:0] t);
        int k;
        k = 0;
        while (r !== t && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        if (r !== t) begin
            n_vec++; n_err++;
            $display("FAIL wait_r: got r=%0d required %0d", r, t);
        end
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        if (done !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL wait_done: got done=%b required 1", done);
        end
        @(negedge clk);
    endtask

    // Monitor: every rising edge of done must match the oldest queued result.
    initial begin
        logic done_q;
        logic [319:0] exp;
        done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (done === 1'b1 && done_q !== 1'b1) begin
                if (sb.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_done: got s_out %h required no result", s_out);
                end else begin
                    exp = sb.pop_front();
                    check("result", s_out, exp);
                end
            end
            done_q = done;
        end
    end

    initial begin
        logic [319:0] v;
        rstn = 1'b1;
        load = 1'b1;
        s_in = rand320();
        #3;
        check("rst_s_out", s_out, 320'd0);
        check("rst_r", {316'd0, r}, 320'd0);
        check("rst_done", {319'd0, done}, 320'd0);
        rstn = 1'b0;
        load = 1'b0;

        // Known answer combined with the counter walk and idle hold.
        start(KAT_IN, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            check("cnt_r", {316'd0, r}, k);
            check("cnt_done", {319'd0, done}, (k == 12) ? 320'd1 : 320'd0);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("hold_r", {316'd0, r}, 320'd12);
            check("hold_done", {319'd0, done}, 320'd1);
            check("hold_s_out", s_out, KAT_OUT);
        end

        for (int n = 0; n < 10; n++) begin
            start(rand320(), 1'b1);
            wait_done();
        end

        // Abort at round 5, then run a fresh input.
        start(rand320(), 1'b0);
        wait_r(4'd5);
        start(rand320(), 1'b1);
        wait_done();

        // s_in changes at r==3 must not affect the result.
        start(rand320(), 1'b1);
        wait_r(4'd3);
        s_in = rand320();
        wait_done();

        // Asynchronous reset mid-run, then immediate start on release with load=0.
        start(rand320(), 1'b0);
        wait_r(4'd4);
        #2;
        rstn = 1'b1;
        #1;
        check("midrst_s_out", s_out, 320'd0);
        check("midrst_r", {316'd0, r}, 320'd0);
        check("midrst_done", {319'd0, done}, 320'd0);
        v = rand320();
        s_in = v;
        sb.push_back(model_p12(v));
        @(negedge clk);
        rstn = 1'b0;
        wait_done();

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 320'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ascon_p.md
ASCON_P -- requirements
Module: ascon_p

Interface
REQ-001 Parameter BW, default 64, lane width in bits; state width is 5*BW; only BW=64 is supported.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rstn  input  1  asynchronous, active-high reset; clears all registers immediately when 1.
REQ-004 load  input  1  synchronous start; when 1 at a clock edge, the counter re-arms to round 0.
REQ-005 s_in  input  5*BW  permutation input; x0=s_in[319:256], x1=[255:192], x2=[191:128], x3=[127:64], x4=[63:0].
REQ-006 s_out  output  5*BW  registered state; same lane order as s_in.
REQ-007 r  output  4  current round index 0..12, for monitoring.
REQ-008 done  output  1  high when 12 rounds are complete and s_out holds the result.

Function
REQ-009 Block SHALL compute Ascon p^12 at one round per clock cycle.
REQ-010 Round input SHALL be s_in when r==0, otherwise the internal state register.
REQ-011 Round constant for round index r SHALL be {(4'hF - r), r[3:0]}: F0,E1,D2,C3,B4,A5,96,87,78,69,5A,4B for r=0..11.
REQ-012 pc: x2 ^= constant (low 8 bits).
REQ-013 ps, in order: x0^=x4; x4^=x3; x2^=x1; t_i=(~x_i)&x_{(i+1) mod 5}; x_i^=t_{(i+1) mod 5}; x1^=x0; x0^=x4; x3^=x2; x2=~x2.
REQ-014 pl, rotate right: x0^=ror(x0,19)^ror(x0,28); x1^=ror(x1,61)^ror(x1,39); x2^=ror(x2,1)^ror(x2,6); x3^=ror(x3,10)^ror(x3,17); x4^=ror(x4,7)^ror(x4,41).
REQ-015 At a rising edge with load=1: r<=0, done<=0, state unchanged; no round is applied.
REQ-016 At a rising edge with load=0 and r<12: state<=round(input,r); r<=r+1.
REQ-017 done SHALL be registered and go to 1 at the same edge where r goes from 11 to 12.
REQ-018 At a rising edge with load=0 and r==12: state, r and done SHALL hold.
REQ-019 load SHALL take priority over round execution at any r, including mid-operation; the active permutation aborts.
REQ-020 Latency: done=1 exactly 12 edges after the load edge, provided load=0 for those 12 edges.
REQ-021 s_in SHALL be sampled only during the cycle with r==0; later changes SHALL NOT affect the result.
REQ-022 With load=0 after reset release, the block SHALL start immediately: round 0 applies to s_in at the first edge.

Reset
REQ-023 While rstn=1: state=0, s_out=0, r=0, done=0, asynchronously and independent of clk.
REQ-024 Asserting rstn mid-permutation SHALL discard the state; the permutation restarts only after release.

Verification
REQ-025 Reset: rstn=1 with arbitrary inputs -> s_out=0, r=0, done=0 with no clock edge.
REQ-026 Known answer: load pulse, then s_in={64'h00400C0000000100,256'h0} with load=0 -> done at edge 12 after load; s_out equals a golden Ascon p^12 model output.
REQ-027 Counter: r steps 0,1,...,12 on consecutive edges; done=0 for r<12; done=1 and r=12 hold for 5 further idle edges.
REQ-028 Back-to-back: 10 random 320-bit s_in, each started by a one-cycle load after done -> every result matches the model; done clears on each load edge.
REQ-029 Abort: load=1 at r=5 -> r=0, done=0; a new s_in runs to completion, and the result matches the model for the new s_in only.
REQ-030 Input stability: change s_in at r=3 -> result matches the model for the value present at r==0.
